shift_autorange: RTL
====================

SHIFT_AUTORANGE -- requirements
Module: shift_autorange

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, meaning the signed sample width of din and dout.
REQ-002 The module SHALL have parameter SHIFT_MAX, default 7, meaning the maximum left-shift amount (range 0..DATA_WIDTH-2).
REQ-003 The module SHALL have parameter SHIFT_INIT, default 4, meaning the shift value after reset (at most SHIFT_MAX).
REQ-004 The module SHALL have parameter WIN_WIDTH, default 16, meaning the width of the window length, threshold and counters.
REQ-005 The module SHALL have these ports, one per line (name, direction, width, meaning):
 clk  input  1  single clock; all logic on its rising edge
 rst_n  input  1  reset, asynchronous assert, active-low
 din  input  DATA_WIDTH  signed sample
 din_valid  input  1  din qualifier
 auto_en  input  1  enables automatic ranging
 manual_shift  input  $clog2(SHIFT_MAX+1)  shift value used when auto_en=0
 win_len  input  WIN_WIDTH  valid samples per decision window
 ovf_thresh  input  WIN_WIDTH  overflow count that must be exceeded to decrement shift
 dout  output  DATA_WIDTH  signed, saturated din<<<shift_value
 dout_valid  output  1  dout qualifier
 ovf  output  1  dout of this sample was saturated
 shift_value  output  $clog2(SHIFT_MAX+1)  shift currently applied
 update  output  1  one-cycle pulse marking each window decision

Function
REQ-006 Datapath latency SHALL be exactly 1 cycle: dout, dout_valid and ovf register the result of the din/din_valid present on the same edge, using the shift_value in effect on that edge.
REQ-007 With s=shift_value, dout SHALL be din*2^s when din lies in [-2^(DATA_WIDTH-1-s), 2^(DATA_WIDTH-1-s)-1]; otherwise +(2^(DATA_WIDTH-1))-1 for positive din, -(2^(DATA_WIDTH-1)) for negative, with ovf=1.
REQ-008 When din_valid=0, dout and ovf SHALL hold, and dout_valid SHALL be 0.
REQ-009 A sample SHALL have "headroom" when din lies in [-2^(DATA_WIDTH-2-s), 2^(DATA_WIDTH-2-s)-1], i.e. it would not saturate at s+1.
REQ-010 The FSM SHALL have states IDLE, ACCUM and UPDATE.
REQ-011 IDLE: shift_value = min(manual_shift, SHIFT_MAX), and all counters are held at 0; the FSM goes to ACCUM when auto_en=1.
REQ-012 ACCUM: each valid sample increments sample_cnt, increments ovf_cnt when ovf-condition holds, and increments hr_cnt when it has headroom. When the sample making sample_cnt equal to max(win_len,1) is accepted, the next state SHALL be UPDATE.
REQ-013 UPDATE: this state SHALL last exactly one cycle and assert update=1 in that cycle.
REQ-014 In UPDATE, if ovf_cnt>ovf_thresh, shift_value SHALL decrement, saturating at 0.
REQ-015 In UPDATE, else if hr_cnt equals the window length, shift_value SHALL increment, saturating at SHIFT_MAX.
REQ-016 In UPDATE, if neither REQ-014 nor REQ-015 applies, shift_value SHALL hold.
REQ-017 UPDATE SHALL clear all counters and return to ACCUM, or to IDLE when auto_en=0.
REQ-018 A valid sample arriving in the UPDATE cycle SHALL be processed with the old shift_value and SHALL NOT be counted in any window.
REQ-019 Deasserting auto_en in ACCUM SHALL go to IDLE next cycle, discarding the partial window without an update pulse. Entering IDLE SHALL load the manual shift.
REQ-020 Counters SHALL saturate at all-ones and SHALL NOT wrap. win_len and ovf_thresh SHALL be sampled every cycle; changing them mid-window takes effect on the next comparison.

Reset
REQ-021 While rst_n=0, the module SHALL immediately set dout=0, dout_valid=0, ovf=0, update=0, shift_value=SHIFT_INIT, state=IDLE and all counters to 0, independent of clk.
REQ-022 After rst_n rises, the first IDLE cycle SHALL apply REQ-011.

Verification (DATA_WIDTH=16, SHIFT_MAX=7, SHIFT_INIT=4)
REQ-023 Assert rst_n=0 mid-window at shift 2 -> outputs 0 and shift_value=4 asynchronously; counters 0; no update pulse.
REQ-024 auto_en=0, manual_shift=4, din=100 valid -> next cycle dout=1600, ovf=0, dout_valid=1. Then manual_shift=7 -> shift_value=7 next cycle.
REQ-025 shift 4: din=3000 -> dout=32767, ovf=1. Then din=-3000 -> dout=-32768, ovf=1. Then din=-2048 -> dout=-32768, ovf=0.
REQ-026 auto_en=1, win_len=8, ovf_thresh=2, shift 4, eight samples din=3000 -> update pulse one cycle after the 8th sample, shift_value=3. Sample in the UPDATE cycle uses shift 4 and is uncounted.
REQ-027 auto_en=1, win_len=8, shift 6, eight samples din=100 -> shift_value=7; a further window of din=100 -> update pulses, shift_value stays 7.
REQ-028 win_len=0 -> update after every valid sample. auto_en dropped after 5 of 8 samples -> IDLE, no update, next window starts from count 0.

Source files
------------

// File: rtl/shift_autorange.sv
// Saturating left shifter whose shift amount is chosen per window from
// overflow and headroom statistics, or taken from manual_shift.
module shift_autorange #(
  parameter int DATA_WIDTH = 16,
  parameter int SHIFT_MAX  = 7,
  parameter int SHIFT_INIT = 4,
  parameter int WIN_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic signed [DATA_WIDTH-1:0]        din,
  input  logic                                din_valid,
  input  logic                                auto_en,
  input  logic [$clog2(SHIFT_MAX+1)-1:0]      manual_shift,
  input  logic [WIN_WIDTH-1:0]                win_len,
  input  logic [WIN_WIDTH-1:0]                ovf_thresh,
  output logic signed [DATA_WIDTH-1:0]        dout,
  output logic                                dout_valid,
  output logic                                ovf,
  output logic [$clog2(SHIFT_MAX+1)-1:0]      shift_value,
  output logic                                update
);

  localparam int SW = $clog2(SHIFT_MAX+1);
  localparam logic [SW-1:0] SMAX  = SW'(SHIFT_MAX);
  localparam logic [SW-1:0] SINIT = SW'(SHIFT_INIT);
  localparam logic [SW-1:0] SONE  = SW'(1);
  localparam logic [WIN_WIDTH-1:0] WONE = WIN_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  state_t state;
  logic [WIN_WIDTH-1:0] sample_cnt;
  logic [WIN_WIDTH-1:0] ovf_cnt;
  logic [WIN_WIDTH-1:0] hr_cnt;

  logic signed [DATA_WIDTH-1:0] sh;
  logic signed [DATA_WIDTH-1:0] sh1;
  logic signed [DATA_WIDTH-1:0] sat;
  logic [SW:0]                  s1;
  logic                         sat_hit;
  logic                         hr;
  logic [SW-1:0]                man_sh;
  logic [WIN_WIDTH-1:0]         win_eff;
  logic [WIN_WIDTH-1:0]         cnt_next;
  logic [WIN_WIDTH-1:0]         ovf_next;
  logic [WIN_WIDTH-1:0]         hr_next;

  // A shift is lossless iff shifting back restores the sample.
  always_comb begin
    sh       = din <<< shift_value;
    s1       = {1'b0, shift_value} + {{SW{1'b0}}, 1'b1};
    sh1      = din <<< s1;
    sat_hit  = (sh >>> shift_value) != din;
    hr       = (sh1 >>> s1) == din;
    sat      = din[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    man_sh   = (manual_shift > SMAX) ? SMAX : manual_shift;
    win_eff  = (win_len == '0) ? WONE : win_len;
    cnt_next = (&sample_cnt) ? sample_cnt : sample_cnt + WONE;
    ovf_next = ovf_cnt;
    if (sat_hit && !(&ovf_cnt))
      ovf_next = ovf_cnt + WONE;
    hr_next  = hr_cnt;
    if (hr && !(&hr_cnt))
      hr_next = hr_cnt + WONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) begin
        dout <= sat_hit ? sat : sh;
        ovf  <= sat_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_value <= SINIT;
      update      <= 1'b0;
      sample_cnt  <= '0;
      ovf_cnt     <= '0;
      hr_cnt      <= '0;
    end else begin
      update <= 1'b0;
      unique case (state)
        IDLE: begin
          shift_value <= man_sh;
          sample_cnt  <= '0;
          ovf_cnt     <= '0;
          hr_cnt      <= '0;
          if (auto_en)
            state <= ACCUM;
        end
        ACCUM: begin
          if (!auto_en) begin
            state       <= IDLE;
            shift_value <= man_sh;
            sample_cnt  <= '0;
            ovf_cnt     <= '0;
            hr_cnt      <= '0;
          end else if (din_valid) begin
            sample_cnt <= cnt_next;
            ovf_cnt    <= ovf_next;
            hr_cnt     <= hr_next;
            if (cnt_next >= win_eff) begin
              state  <= UPDATE;
              update <= 1'b1;
            end
          end
        end
        UPDATE: begin
          sample_cnt <= '0;
          ovf_cnt    <= '0;
          hr_cnt     <= '0;
          if (!auto_en) begin
            state       <= IDLE;
            shift_value <= man_sh;
          end else begin
            state <= ACCUM;
            if (ovf_cnt > ovf_thresh) begin
              if (shift_value != '0)
                shift_value <= shift_value - SONE;
            end else if (hr_cnt == win_eff) begin
              if (shift_value != SMAX)
                shift_value <= shift_value + SONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
